// File: rtl/regiset_pkg.sv
// regiset_pkg: mode encodings and width helpers shared by the register bank
// and its entry sub-module.
package regiset_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  // Address width for a bank of the given depth, never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: one extra bit so the value DEPTH is representable.
  function automatic int count_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/regiset_entry.sv
// regiset_entry: one storage word (data plus optional parity) with load
// enable and asynchronous active-low reset.
module regiset_entry #(
  parameter int EW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [EW-1:0] d,
  output logic [EW-1:0] q
);

  // Capture the next word when enabled; reset clears the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regiset_bank.sv
// regiset_bank: DEPTH x WIDTH register bank with per-entry valid bits,
// hold/load/shift/clear modes, a registered read port and an occupancy count.
// Optional feature: define REGISET_PARITY_EN to store an even-parity bit per
// entry and flag mismatches on read through Par_err (tied low otherwise).
module regiset_bank
  import regiset_pkg::*;
#(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din,
  input  logic             Ce,
  input  logic [1:0]       Mode,
  input  logic [AW-1:0]    WAddr,
  input  logic [AW-1:0]    RAddr,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  output logic [AW:0]      Count,
  output logic             Full,
  output logic             Par_err
);

`ifdef REGISET_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int          EW      = WIDTH + PW;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [EW-1:0]    ent_q [DEPTH];
  logic [EW-1:0]    ent_d [DEPTH];
  logic [DEPTH-1:0] ent_en;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [EW-1:0]    din_ent;
  logic             waddr_ok;
  logic [AW:0]      count_q;

  logic [EW-1:0]    rd_ent_p0;
  logic             rd_vld_p0;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;

  // Number of set bits in a valid vector.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + {{AW{1'b0}}, v[i]};
    end
    return n;
  endfunction

`ifdef REGISET_PARITY_EN
  assign din_ent = {^Din, Din};
`else
  assign din_ent = Din;
`endif

  assign waddr_ok = ({1'b0, WAddr} < DEPTH_V);

  // Next-value mux: decide which entries load and what they load per mode.
  always_comb begin
    ent_en = '0;
    vld_d  = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = din_ent;
    end
    if (Ce) begin
      case (Mode)
        MODE_LOAD: begin
          if (waddr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (WAddr == AW'(i)) begin
                ent_en[i] = 1'b1;
                vld_d[i]  = 1'b1;
              end
            end
          end
        end
        MODE_SHIFT: begin
          ent_en = '1;
          vld_d  = {vld_q[DEPTH-2:0], 1'b1};
          for (int i = 1; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
          end
        end
        MODE_CLEAR: begin
          ent_en = '1;
          vld_d  = '0;
          for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    regiset_entry #(
      .EW (EW)
    ) u_entry (
      .clk   (CLK),
      .rst_n (RST),
      .en    (ent_en[g]),
      .d     (ent_d[g]),
      .q     (ent_q[g])
    );
  end

  // Valid bits and occupancy move together on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= popcount(vld_d);
    end
  end

  assign Count = count_q;
  assign Full  = (count_q == DEPTH_V);

  // Read select on pre-edge contents; out-of-range addresses match no entry.
  always_comb begin
    rd_ent_p0 = '0;
    rd_vld_p0 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RAddr == AW'(i)) begin
        rd_ent_p0 = ent_q[i];
        rd_vld_p0 = vld_q[i];
      end
    end
  end

  // ---- stage p0 -> p1: registered read port ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      dout_p1 <= rd_ent_p0[WIDTH-1:0];
      vld_p1  <= rd_vld_p0;
    end
  end

  assign Dout       = dout_p1;
  assign Dout_valid = vld_p1;

`ifdef REGISET_PARITY_EN
  logic perr_p1;

  // Parity check on the word being read, reported alongside Dout.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perr_p1 <= 1'b0;
    end else begin
      perr_p1 <= rd_vld_p0 & (rd_ent_p0[WIDTH] != ^rd_ent_p0[WIDTH-1:0]);
    end
  end

  assign Par_err = perr_p1;
`else
  assign Par_err = 1'b0;
`endif

endmodule

// File: tb/tb_regiset_bank.sv
// tb_regiset_bank: directed self-checking bench for regiset_bank (DEPTH=8
// main instance, DEPTH=6 instance for out-of-range addressing).
module tb_regiset_bank;
  import regiset_pkg::*;

  logic        CLK;
  logic        RST;

  logic [11:0] din;
  logic        ce;
  logic [1:0]  mode;
  logic [2:0]  waddr;
  logic [2:0]  raddr;
  logic [11:0] dout;
  logic        dv;
  logic [3:0]  cnt;
  logic        full;
  logic        perr;

  logic [11:0] din6;
  logic        ce6;
  logic [1:0]  mode6;
  logic [2:0]  waddr6;
  logic [2:0]  raddr6;
  logic [11:0] dout6;
  logic        dv6;
  logic [3:0]  cnt6;
  logic        full6;
  logic        perr6;

  int checks;
  int failures;

  regiset_bank #(.WIDTH(12), .DEPTH(8)) u8 (
    .CLK(CLK), .RST(RST), .Din(din), .Ce(ce), .Mode(mode), .WAddr(waddr),
    .RAddr(raddr), .Dout(dout), .Dout_valid(dv), .Count(cnt), .Full(full),
    .Par_err(perr)
  );

  regiset_bank #(.WIDTH(12), .DEPTH(6)) u6 (
    .CLK(CLK), .RST(RST), .Din(din6), .Ce(ce6), .Mode(mode6), .WAddr(waddr6),
    .RAddr(raddr6), .Dout(dout6), .Dout_valid(dv6), .Count(cnt6), .Full(full6),
    .Par_err(perr6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    din = 12'hFFF; ce = 1'b1; mode = MODE_LOAD; waddr = 3'd1; raddr = 3'd1;
    din6 = '0; ce6 = 1'b0; mode6 = MODE_HOLD; waddr6 = '0; raddr6 = '0;
    tick();
    tick();
    checks++; if (dout !== 12'h000) begin failures++; $display("FAIL reset_dout got=%h exp=%h", dout, 12'h000); end
    checks++; if (dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", dv); end
    checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", perr); end
    checks++; if (cnt6 !== 4'd0) begin failures++; $display("FAIL reset_count6 got=%0d exp=0", cnt6); end
    mode = MODE_HOLD;
    RST = 1'b1;
    tick();
  endtask

  task automatic test_load();
    din = 12'hABC; ce = 1'b1; mode = MODE_LOAD; waddr = 3'd3; raddr = 3'd3;
    tick();
    checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL load_count got=%0d exp=1", cnt); end
    checks++; if (dv !== 1'b0) begin failures++; $display("FAIL load_rbw_dv got=%b exp=0", dv); end
    mode = MODE_HOLD;
    tick();
    checks++; if (dout !== 12'hABC) begin failures++; $display("FAIL load_dout got=%h exp=%h", dout, 12'hABC); end
    checks++; if (dv !== 1'b1) begin failures++; $display("FAIL load_dv got=%b exp=1", dv); end
  endtask

  task automatic test_ce_gating();
    logic [11:0] exp_v [4];
    exp_v[0] = 12'h100; exp_v[1] = 12'h101; exp_v[2] = 12'h102; exp_v[3] = 12'hABC;
    ce = 1'b1; mode = MODE_LOAD;
    for (int i = 0; i < 3; i++) begin
      waddr = 3'(i); din = exp_v[i];
      tick();
    end
    checks++; if (cnt !== 4'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", cnt); end
    ce = 1'b0; mode = MODE_CLEAR;
    for (int i = 0; i < 5; i++) begin
      raddr = 3'(i % 4);
      tick();
      checks++; if (cnt !== 4'd4) begin failures++; $display("FAIL cegate_count cyc=%0d got=%0d exp=4", i, cnt); end
    end
    for (int i = 0; i < 4; i++) begin
      raddr = 3'(i);
      tick();
      checks++; if (dout !== exp_v[i] || dv !== 1'b1) begin failures++; $display("FAIL cegate_data idx=%0d got=%h/%b exp=%h/1", i, dout, dv, exp_v[i]); end
    end
    ce = 1'b1; mode = MODE_CLEAR;
    tick();
    checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", cnt); end
    ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i);
      tick();
      checks++; if (dv !== 1'b0 || dout !== 12'h000) begin failures++; $display("FAIL clear_read idx=%0d got=%h/%b exp=000/0", i, dout, dv); end
    end
  endtask

  task automatic test_shift();
    ce = 1'b1; mode = MODE_SHIFT;
    for (int d = 1; d <= 9; d++) begin
      din = 12'(d);
      tick();
      if (d == 7) begin
        checks++; if (cnt !== 4'd7 || full !== 1'b0) begin failures++; $display("FAIL shift7_count got=%0d/%b exp=7/0", cnt, full); end
      end
    end
    checks++; if (cnt !== 4'd8) begin failures++; $display("FAIL shift_count got=%0d exp=8", cnt); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL shift_full got=%b exp=1", full); end
    mode = MODE_HOLD;
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i);
      tick();
      checks++; if (dout !== 12'(9 - i) || dv !== 1'b1) begin failures++; $display("FAIL shift_data idx=%0d got=%h/%b exp=%h/1", i, dout, dv, 12'(9 - i)); end
    end
  endtask

  task automatic test_same_addr();
    ce = 1'b1; mode = MODE_LOAD; waddr = 3'd5; raddr = 3'd5; din = 12'h111;
    tick();
    din = 12'h222;
    tick();
    checks++; if (dout !== 12'h111) begin failures++; $display("FAIL same_addr_old got=%h exp=111", dout); end
    mode = MODE_HOLD;
    tick();
    checks++; if (dout !== 12'h222) begin failures++; $display("FAIL same_addr_new got=%h exp=222", dout); end
    checks++; if (cnt !== 4'd8) begin failures++; $display("FAIL overwrite_count got=%0d exp=8", cnt); end
  endtask

  task automatic test_out_of_range();
    ce6 = 1'b1; mode6 = MODE_LOAD; waddr6 = 3'd1; din6 = 12'h0AA;
    tick();
    checks++; if (cnt6 !== 4'd1) begin failures++; $display("FAIL oor_setup_count got=%0d exp=1", cnt6); end
    waddr6 = 3'd7; din6 = 12'hFFF;
    tick();
    checks++; if (cnt6 !== 4'd1) begin failures++; $display("FAIL oor_write_count got=%0d exp=1", cnt6); end
    mode6 = MODE_HOLD;
    for (int i = 0; i < 6; i++) begin
      raddr6 = 3'(i);
      tick();
      if (i == 1) begin
        checks++; if (dout6 !== 12'h0AA || dv6 !== 1'b1) begin failures++; $display("FAIL oor_keep idx=%0d got=%h/%b exp=0aa/1", i, dout6, dv6); end
      end else begin
        checks++; if (dout6 !== 12'h000 || dv6 !== 1'b0) begin failures++; $display("FAIL oor_other idx=%0d got=%h/%b exp=000/0", i, dout6, dv6); end
      end
    end
    raddr6 = 3'd6;
    tick();
    checks++; if (dout6 !== 12'h000 || dv6 !== 1'b0) begin failures++; $display("FAIL oor_read6 got=%h/%b exp=000/0", dout6, dv6); end
    raddr6 = 3'd1;
    tick();
    raddr6 = 3'd7;
    tick();
    checks++; if (dout6 !== 12'h000 || dv6 !== 1'b0) begin failures++; $display("FAIL oor_read7 got=%h/%b exp=000/0", dout6, dv6); end
  endtask

  task automatic test_parity();
`ifdef REGISET_PARITY_EN
    logic [12:0] bad;
    ce = 1'b1; mode = MODE_LOAD; waddr = 3'd2; din = 12'h0F1;
    tick();
    bad = {^12'h0F1, 12'h0F0};
    force u8.g_ent[2].u_entry.q = bad;
    mode = MODE_HOLD; raddr = 3'd2;
    tick();
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL parity_err got=%b exp=1", perr); end
    release u8.g_ent[2].u_entry.q;
    raddr = 3'd0;
    tick();
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL parity_clean got=%b exp=0", perr); end
`else
    ce = 1'b1; mode = MODE_LOAD; waddr = 3'd2; din = 12'h0F1;
    tick();
    mode = MODE_HOLD; raddr = 3'd2;
    tick();
    checks++; if (dout !== 12'h0F1 || perr !== 1'b0) begin failures++; $display("FAIL parity_off got=%h/%b exp=0f1/0", dout, perr); end
`endif
  endtask

  task automatic test_mid_reset();
    ce = 1'b1; mode = MODE_HOLD; raddr = 3'd5;
    tick();
    checks++; if (dout !== 12'h222 || full !== 1'b1) begin failures++; $display("FAIL prereset got=%h/%b exp=222/1", dout, full); end
    RST = 1'b0;
    #1;
    checks++; if (cnt !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL async_count got=%0d/%b exp=0/0", cnt, full); end
    checks++; if (dout !== 12'h000 || dv !== 1'b0) begin failures++; $display("FAIL async_read got=%h/%b exp=000/0", dout, dv); end
    checks++; if (cnt6 !== 4'd0) begin failures++; $display("FAIL async_count6 got=%0d exp=0", cnt6); end
    tick();
    RST = 1'b1;
    tick();
    checks++; if (dv !== 1'b0 || cnt !== 4'd0) begin failures++; $display("FAIL post_reset got=%b/%0d exp=0/0", dv, cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load();
    test_ce_gating();
    test_shift();
    test_same_addr();
    test_out_of_range();
    test_parity();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
